// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 16-bit word stream of the 64-bit LFSR generator: self-synchronises, then predicts and compares.
// Define LFSR_CHECKER_BIT_ERR_EN to make err_count accumulate bit errors instead of erroneous words.
module lfsr_stream_checker #(
   parameter int ERR_THRESH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [15:0]      rnd_number,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] word_count
);

   localparam logic [0:0] ST_ACQUIRE = 1'b0;
   localparam logic [0:0] ST_LOCKED  = 1'b1;
   localparam logic [5:0] ACQ_LAST   = 6'd48;
   localparam logic [3:0] THRESH     = 4'(ERR_THRESH);

   logic [0:0]       state;
   logic [5:0]       acq_cnt;
   logic [63:0]      shadow;
   logic [14:0]      prev_word;
   logic [3:0]       cons_cnt;

   logic [63:0]      pred;
   logic [63:0]      shifted;
   logic             mismatch;
   logic [4:0]       err_inc;
   logic [CNT_W:0]   err_sum;
   logic [CNT_W-1:0] err_next;
   logic [CNT_W-1:0] word_next;

   function automatic logic [63:0] lfsr_next(input logic [63:0] s);
      return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
   endfunction

`ifdef LFSR_CHECKER_BIT_ERR_EN
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
      return n;
   endfunction
`endif

   // Next-word prediction and saturating counter arithmetic.
   always_comb begin
      pred     = lfsr_next(shadow);
      shifted  = {shadow[62:0], rnd_number[0]};
      mismatch = (rnd_number != pred[15:0]);
`ifdef LFSR_CHECKER_BIT_ERR_EN
      err_inc  = popcount16(rnd_number ^ pred[15:0]);
`else
      err_inc  = 5'd1;
`endif
      err_sum   = {1'b0, err_count} + (CNT_W+1)'(err_inc);
      err_next  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      word_next = (&word_count) ? word_count : word_count + CNT_W'(1);
   end

   assign locked = (state == ST_LOCKED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_ACQUIRE;
         acq_cnt    <= '0;
         shadow     <= '0;
         prev_word  <= '0;
         cons_cnt   <= '0;
         err_pulse  <= 1'b0;
         err_count  <= '0;
         word_count <= '0;
      end else if (clear) begin
         state      <= ST_ACQUIRE;
         acq_cnt    <= '0;
         cons_cnt   <= '0;
         err_pulse  <= 1'b0;
         err_count  <= '0;
         word_count <= '0;
      end else begin
         err_pulse <= 1'b0;
         if (en) begin
            if (state == ST_ACQUIRE) begin
               // A word that breaks the shift relation becomes the first word of a new attempt.
               if (acq_cnt == '0 || rnd_number[15:1] != prev_word) begin
                  shadow    <= {48'b0, rnd_number};
                  prev_word <= rnd_number[14:0];
                  acq_cnt   <= 6'd1;
               end else begin
                  shadow    <= shifted;
                  prev_word <= rnd_number[14:0];
                  if (acq_cnt == ACQ_LAST) begin
                     acq_cnt <= '0;
                     if (shifted != '0) state <= ST_LOCKED;
                  end else begin
                     acq_cnt <= acq_cnt + 6'd1;
                  end
               end
            end else begin
               // Flywheel: the local copy advances whether or not the word matched.
               shadow     <= pred;
               word_count <= word_next;
               if (mismatch) begin
                  err_pulse <= 1'b1;
                  err_count <= err_next;
                  if (cons_cnt + 4'd1 == THRESH) begin
                     state    <= ST_ACQUIRE;
                     acq_cnt  <= '0;
                     cons_cnt <= '0;
                  end else begin
                     cons_cnt <= cons_cnt + 4'd1;
                  end
               end else begin
                  cons_cnt <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Self-checking bench for lfsr_stream_checker: scenario table, directed sequences and a randomized stream
// checked against a word-level reference model.
module tb_lfsr_stream_checker;

   localparam int ERR_THRESH = 4;
   localparam int CNT_W      = 8;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             en;
   logic [15:0]      rnd_number;
   logic             clear;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] word_count;

   int total;
   int bad;

   logic [63:0] gen_state;

   // Reference model: acquisition as a run of chained words, lock as a free-running LFSR copy.
   bit          m_locked;
   bit          m_pulse;
   int          m_err;
   int          m_wc;
   int          m_cons;
   logic [63:0] m_state;
   logic [15:0] m_run[$];

   typedef struct {
      logic [15:0] mask;
      int          n_bad;
      int          exp_pulses;
      int          exp_words;
      int          exp_bits;
      bit          exp_locked;
   } vec_t;

   vec_t vecs[4];

   lfsr_stream_checker #(
      .ERR_THRESH(ERR_THRESH),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .rnd_number(rnd_number),
      .clear     (clear),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .word_count(word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      logic fb;
      fb = s[63] ^ s[62] ^ s[60] ^ s[59];
      return {s[62:0], fb};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic model_reset();
      m_locked = 0;
      m_pulse  = 0;
      m_err    = 0;
      m_wc     = 0;
      m_cons   = 0;
      m_state  = '0;
      m_run.delete();
   endtask

   task automatic model_step(input bit e, input logic [15:0] w, input bit c);
      logic [15:0] last;
      logic [63:0] st;
      if (c) begin
         model_reset();
      end else begin
         m_pulse = 0;
         if (e && !m_locked) begin
            if (m_run.size() != 0) last = m_run[m_run.size()-1];
            else last = '0;
            if (m_run.size() == 0 || w[15:1] != last[14:0]) m_run.delete();
            m_run.push_back(w);
            if (m_run.size() == 49) begin
               st = {m_run[0], 48'b0};
               for (int i = 1; i < 49; i++) st[48-i] = m_run[i][0];
               m_run.delete();
               if (st != '0) begin
                  m_locked = 1;
                  m_state  = st;
               end
            end
         end else if (e) begin
            m_state = lfsr_step(m_state);
            if (m_wc < CNT_MAX) m_wc++;
            if (w != m_state[15:0]) begin
               m_pulse = 1;
`ifdef LFSR_CHECKER_BIT_ERR_EN
               m_err = m_err + $countones(w ^ m_state[15:0]);
`else
               m_err = m_err + 1;
`endif
               if (m_err > CNT_MAX) m_err = CNT_MAX;
               m_cons++;
               if (m_cons == ERR_THRESH) begin
                  m_locked = 0;
                  m_cons   = 0;
               end
            end else begin
               m_cons = 0;
            end
         end
      end
   endtask

   // One clock: drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
   task automatic applyStimulus(input bit e, input logic [15:0] w, input bit c);
      en         = e;
      rnd_number = w;
      clear      = c;
      @(posedge clk);
      model_step(e, w, c);
      @(negedge clk);
      checkOutput("model_locked", locked, m_locked);
      checkOutput("model_err_pulse", err_pulse, m_pulse);
      checkOutput("model_err_count", err_count, m_err);
      checkOutput("model_word_count", word_count, m_wc);
   endtask

   task automatic send(input logic [15:0] mask);
      gen_state = lfsr_step(gen_state);
      applyStimulus(1'b1, gen_state[15:0] ^ mask, 1'b0);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 16'($urandom), 1'b0);
   endtask

   task automatic wait_lock(input int budget, output int n);
      n = 0;
      while (!locked && n < budget) begin
         send(16'h0000);
         n++;
      end
      if (!locked) checkOutput("lock_timeout", locked, 1);
   endtask

   task automatic async_reset_check(input string tag);
      #2 rst = 1'b1;
      #1;
      checkOutput({tag, "_locked"}, locked, 0);
      checkOutput({tag, "_err_pulse"}, err_pulse, 0);
      checkOutput({tag, "_err_count"}, err_count, 0);
      checkOutput({tag, "_word_count"}, word_count, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      int pulses;
      int base;
      int exp_delta;
      int r;
      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      en         = 1'b0;
      clear      = 1'b0;
      rnd_number = '0;
      gen_state  = 64'hACE1_ACE1_ACE1_ACE1;
      model_reset();

      vecs[0] = '{mask: 16'h0001, n_bad: 1, exp_pulses: 1, exp_words: 1, exp_bits: 1,  exp_locked: 1'b1};
      vecs[1] = '{mask: 16'hFFFF, n_bad: 3, exp_pulses: 3, exp_words: 3, exp_bits: 48, exp_locked: 1'b1};
      vecs[2] = '{mask: 16'hFFFF, n_bad: 4, exp_pulses: 4, exp_words: 4, exp_bits: 64, exp_locked: 1'b0};
      vecs[3] = '{mask: 16'h00F0, n_bad: 2, exp_pulses: 2, exp_words: 2, exp_bits: 8,  exp_locked: 1'b1};

      #12;
      checkOutput("reset_locked", locked, 0);
      checkOutput("reset_err_pulse", err_pulse, 0);
      checkOutput("reset_err_count", err_count, 0);
      checkOutput("reset_word_count", word_count, 0);
      @(negedge clk);
      rst = 1'b0;

      // Clean continuous stream: lock after exactly 49 words, then count 100 checked words.
      for (int i = 0; i < 48; i++) send(16'h0000);
      checkOutput("not_locked_after_48", locked, 0);
      send(16'h0000);
      checkOutput("locked_after_49", locked, 1);
      repeat (100) send(16'h0000);
      checkOutput("word_count_100", word_count, 100);
      checkOutput("clean_err_count", err_count, 0);

      // Corruption scenarios while locked.
      for (int v = 0; v < 4; v++) begin
         if (!locked) wait_lock(200, n);
         base   = int'(err_count);
         pulses = 0;
         for (int k = 0; k < vecs[v].n_bad; k++) begin
            send(vecs[v].mask);
            pulses += int'(err_pulse);
         end
         checkOutput("vec_locked", locked, vecs[v].exp_locked);
         send(16'h0000);
         checkOutput("vec_clean_pulse", err_pulse, 0);
         pulses += int'(err_pulse);
         checkOutput("vec_pulses", pulses, vecs[v].exp_pulses);
`ifdef LFSR_CHECKER_BIT_ERR_EN
         exp_delta = vecs[v].exp_bits;
`else
         exp_delta = vecs[v].exp_words;
`endif
         checkOutput("vec_err_delta", int'(err_count) - base, exp_delta);
         if (!vecs[v].exp_locked) begin
            wait_lock(200, n);
            checkOutput("relock_words", n + 1, 49);
         end
      end

      // Gapped stream: clear with a valid word (discarded), then three idle cycles between words.
      gen_state = lfsr_step(gen_state);
      applyStimulus(1'b1, gen_state[15:0], 1'b1);
      checkOutput("clear_en_locked", locked, 0);
      checkOutput("clear_en_word_count", word_count, 0);
      n = 0;
      while (!locked && n < 100) begin
         send(16'h0000);
         n++;
         if (!locked) repeat (3) idle();
      end
      checkOutput("gapped_lock_words", n, 49);
      for (int i = 0; i < 10; i++) begin
         repeat (3) idle();
         send(16'h0000);
      end
      checkOutput("gapped_word_count", word_count, 10);
      checkOutput("gapped_err_count", err_count, 0);

      // Broken shift relation at word 20: both it and its successor restart acquisition.
      applyStimulus(1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 19; i++) send(16'h0000);
      send(16'h0002);
      n = 0;
      while (!locked && n < 100) begin
         send(16'h0000);
         n++;
      end
      checkOutput("restart_lock_words", n, 49);
      send(16'h0000);
      checkOutput("restart_err_count", err_count, 0);

      // Seven isolated errors, clear while locked, then asynchronous reset mid-acquire.
      for (int i = 0; i < 7; i++) begin
         send(16'h0001);
         send(16'h0000);
      end
      checkOutput("seven_err_count", err_count, 7);
      checkOutput("seven_locked", locked, 1);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("clear_err_count", err_count, 0);
      checkOutput("clear_word_count", word_count, 0);
      checkOutput("clear_locked", locked, 0);
      repeat (20) send(16'h0000);
      async_reset_check("rst_acquire");

      // Saturation of both counters (two errors, one clean word, repeated).
      wait_lock(200, n);
      for (int i = 0; i < 130; i++) begin
         send(16'h0001);
         send(16'h0001);
         send(16'h0000);
      end
      checkOutput("sat_err_count", err_count, CNT_MAX);
      checkOutput("sat_word_count", word_count, CNT_MAX);
      checkOutput("sat_locked", locked, 1);

      // Randomized stream with occasional corruption, gaps and clears.
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            gen_state = lfsr_step(gen_state);
            applyStimulus(1'($urandom_range(0, 1)), gen_state[15:0], 1'b1);
         end else if (r < 25) begin
            idle();
         end else if ($urandom_range(0, 15) == 0) begin
            send(16'($urandom_range(1, 65535)));
         end else begin
            send(16'h0000);
         end
      end
      if (!locked) wait_lock(200, n);
      send(16'h0001);
      async_reset_check("rst_locked");
      send(16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
